dff_bank_ctrl: RTL and testbench

- Sequencing and sharing controller for a bank of WIDTH synchronous-preset/clear D flip-flops.
- Each flip-flop has pre, clr, d and q. On each clk edge it responds to {pre,clr}:
  - 10: set.
  - 01: clear.
  - 00: load d.
  - 11: hold.
- Two requesters issue WRITE/CLEAR/PRESET/READ commands. A round-robin arbiter picks one.
- An FSM drives the bank's pre/clr/d vectors for exactly one edge, then reads back q and reports completion and mismatch.

---
 rtl/dff_ctrl_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 48 ++++
 rtl/dff_bank_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dff_bank_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_ctrl_pkg.sv
// dff_ctrl_pkg
// Shared definitions for the flip-flop bank controller:
//   cmd_t   - requester command codes (WRITE/CLEAR/PRESET/READ)
//   state_t - controller state encoding (IDLE/APPLY/VERIFY)
//   HOLD_PRE/HOLD_CLR - per-bit control pair that makes a bank flop hold
package dff_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE  = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_PRESET = 2'b10,
    CMD_READ   = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    APPLY  = 2'b01,
    VERIFY = 2'b10
  } state_t;

  // {pre,clr} = 11 leaves a bank flop unchanged
  localparam logic HOLD_PRE = 1'b1;
  localparam logic HOLD_CLR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter.
// Ports:
//   clk      - rising-edge clock
//   clr_n    - synchronous active-low reset; after reset requester 0 is favoured
//   req      - request vector, bit0 = requester 0
//   grant_en - high when the caller will act on the winner this cycle
//   winner   - combinational one-hot winner (zero when req is zero)
module rr_arb2 (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] winner
);

  // last_q remembers which requester was granted last; resetting it to 1
  // makes requester 0 win the first contested round.
  logic last_q;
  logic last_d;

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_q ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

  // The pointer only moves when a grant is actually issued
  always_comb begin
    last_d = last_q;
    if (grant_en && (winner != 2'b00)) begin
      last_d = winner[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dff_bank_ctrl.sv
// dff_bank_ctrl
// Sequencing/sharing controller for a bank of WIDTH preset/clear D flops.
// Two requesters issue WRITE/CLEAR/PRESET/READ; a round-robin arbiter picks
// one, the controller drives the bank controls for exactly one edge, then
// reads the bank back and reports completion and mismatch.
// Ports:
//   clk, clr_n          - clock and synchronous active-low reset
//   req, cmd0/1, data0/1 - requester interface (data = value or bit mask)
//   gnt                 - one-hot one-cycle grant pulse
//   busy                - high while not IDLE
//   done, done_id       - completion pulse and requester it belongs to
//   err, rdata          - readback mismatch flag and readback value
//   ff_pre/ff_clr/ff_d  - per-bit controls to the bank
//   ff_q                - per-bit outputs from the bank
module dff_bank_ctrl
  import dff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [1:0]       req,
  input  logic [1:0]       cmd0,
  input  logic [WIDTH-1:0] data0,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] ff_pre,
  output logic [WIDTH-1:0] ff_clr,
  output logic [WIDTH-1:0] ff_d,
  input  logic [WIDTH-1:0] ff_q
);

  localparam logic [WIDTH-1:0] PRE_IDLE = {WIDTH{HOLD_PRE}};
  localparam logic [WIDTH-1:0] CLR_IDLE = {WIDTH{HOLD_CLR}};

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] q_old_q, q_old_d;
  logic             id_q, id_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] ff_pre_q, ff_pre_d;
  logic [WIDTH-1:0] ff_clr_q, ff_clr_d;
  logic [WIDTH-1:0] ff_d_q, ff_d_d;

  logic [1:0]       arb_win;
  logic             arb_en;
  logic             sel;
  cmd_t             sel_cmd;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] exp_val;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .grant_en (arb_en),
    .winner   (arb_win)
  );

  assign sel      = arb_win[1];
  assign sel_cmd  = sel ? cmd_t'(cmd1) : cmd_t'(cmd0);
  assign sel_data = sel ? data1 : data0;

  // Value the bank should hold after the op, given the snapshot taken at grant
  always_comb begin
    exp_val = '0;
    case (cmd_q)
      CMD_WRITE:  exp_val = data_q;
      CMD_CLEAR:  exp_val = q_old_q & ~data_q;
      CMD_PRESET: exp_val = q_old_q | data_q;
      default:    exp_val = ff_q;
    endcase
  end

  // Next-state and output logic. Controls are only away from hold during
  // the single APPLY cycle so the bank captures exactly one edge.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    q_old_d   = q_old_q;
    id_d      = id_q;
    gnt_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    ff_pre_d  = ff_pre_q;
    ff_clr_d  = ff_clr_q;
    ff_d_d    = ff_d_q;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          cmd_d   = sel_cmd;
          data_d  = sel_data;
          q_old_d = ff_q;
          id_d    = sel;
          gnt_d   = arb_win;
          state_d = APPLY;
          ff_d_d  = '0;
          // CLEAR/PRESET: mask bits pull one control low, others stay at hold
          case (sel_cmd)
            CMD_WRITE: begin
              ff_pre_d = '0;
              ff_clr_d = '0;
              ff_d_d   = sel_data;
            end
            CMD_CLEAR: begin
              ff_pre_d = ~sel_data;
              ff_clr_d = CLR_IDLE;
            end
            CMD_PRESET: begin
              ff_pre_d = PRE_IDLE;
              ff_clr_d = ~sel_data;
            end
            default: begin
              ff_pre_d = PRE_IDLE;
              ff_clr_d = CLR_IDLE;
            end
          endcase
        end
      end
      APPLY: begin
        ff_pre_d = PRE_IDLE;
        ff_clr_d = CLR_IDLE;
        ff_d_d   = '0;
        state_d  = VERIFY;
      end
      VERIFY: begin
        rdata_d   = ff_q;
        done_d    = 1'b1;
        done_id_d = id_q;
        err_d     = (cmd_q == CMD_READ) ? 1'b0 : (ff_q != exp_val);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Reset returns controls to hold but leaves the bank alone; a reset edge
  // that ends APPLY still lets the bank capture, since controls were live.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_WRITE;
      data_q    <= '0;
      q_old_q   <= '0;
      id_q      <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ff_pre_q  <= PRE_IDLE;
      ff_clr_q  <= CLR_IDLE;
      ff_d_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      q_old_q   <= q_old_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ff_pre_q  <= ff_pre_d;
      ff_clr_q  <= ff_clr_d;
      ff_d_q    <= ff_d_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign ff_pre  = ff_pre_q;
  assign ff_clr  = ff_clr_q;
  assign ff_d    = ff_d_q;

endmodule

// File: tb/tb_dff_bank_ctrl.sv
// tb_dff_bank_ctrl
// Directed bench for dff_bank_ctrl with a behavioural flip-flop bank model
// (optionally forcing q bit0 low) driven by the controller outputs.
module tb_dff_bank_ctrl;

  localparam logic [1:0] C_WRITE  = 2'b00;
  localparam logic [1:0] C_CLEAR  = 2'b01;
  localparam logic [1:0] C_PRESET = 2'b10;
  localparam logic [1:0] C_READ   = 2'b11;

  logic       clk;
  logic       clr_n;
  logic [1:0] req;
  logic [1:0] cmd0;
  logic [7:0] data0;
  logic [1:0] cmd1;
  logic [7:0] data1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       done_id;
  logic       err;
  logic [7:0] rdata;
  logic [7:0] ff_pre;
  logic [7:0] ff_clr;
  logic [7:0] ff_d;
  logic [7:0] ff_q;

  logic [7:0] bank_q = 8'h00;
  logic       stuck  = 1'b0;

  int total = 0;
  int bad   = 0;

  dff_bank_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (req),
    .cmd0    (cmd0),
    .data0   (data0),
    .cmd1    (cmd1),
    .data1   (data1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .err     (err),
    .rdata   (rdata),
    .ff_pre  (ff_pre),
    .ff_clr  (ff_clr),
    .ff_d    (ff_d),
    .ff_q    (ff_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flip-flop bank: {pre,clr} 10 set, 01 clear, 00 load d, 11 hold
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      case ({ff_pre[i], ff_clr[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b00:   bank_q[i] <= ff_d[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  assign ff_q = stuck ? {bank_q[7:1], 1'b0} : bank_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] c0,
                               input logic [7:0] d0, input logic [1:0] c1,
                               input logic [7:0] d1);
    req   = r;
    cmd0  = c0;
    data0 = d0;
    cmd1  = c1;
    data1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_gnt"},     {30'd0, gnt},   32'h0);
    checkOutput({tag, "_busy"},    {31'd0, busy},  32'h0);
    checkOutput({tag, "_done"},    {31'd0, done},  32'h0);
    checkOutput({tag, "_ff_pre"},  {24'd0, ff_pre}, 32'hFF);
    checkOutput({tag, "_ff_clr"},  {24'd0, ff_clr}, 32'hFF);
    checkOutput({tag, "_ff_d"},    {24'd0, ff_d},  32'h0);
  endtask

  logic [7:0] alt_rdata [4];

  initial begin
    $display("[TB] start");
    clr_n = 1'b0;
    applyStimulus(2'b00, C_WRITE, 8'h00, C_WRITE, 8'h00);
    tick();
    tick();

    // Reset values
    checkIdleOutputs("rst");
    checkOutput("rst_done_id", {31'd0, done_id}, 32'h0);
    checkOutput("rst_err",     {31'd0, err},     32'h0);
    checkOutput("rst_rdata",   {24'd0, rdata},   32'h0);
    clr_n = 1'b1;
    tick();
    checkIdleOutputs("idle_noreq");

    // WRITE A5 from requester 0
    applyStimulus(2'b01, C_WRITE, 8'hA5, C_WRITE, 8'h00);
    tick();
    checkOutput("wr_gnt",    {30'd0, gnt},    32'h1);
    checkOutput("wr_busy",   {31'd0, busy},   32'h1);
    checkOutput("wr_pre",    {24'd0, ff_pre}, 32'h00);
    checkOutput("wr_clr",    {24'd0, ff_clr}, 32'h00);
    checkOutput("wr_d",      {24'd0, ff_d},   32'hA5);
    req = 2'b00;
    tick();
    checkOutput("wr_v_gnt",  {30'd0, gnt},    32'h0);
    checkOutput("wr_v_pre",  {24'd0, ff_pre}, 32'hFF);
    checkOutput("wr_v_clr",  {24'd0, ff_clr}, 32'hFF);
    checkOutput("wr_v_done", {31'd0, done},   32'h0);
    tick();
    checkOutput("wr_done",   {31'd0, done},    32'h1);
    checkOutput("wr_id",     {31'd0, done_id}, 32'h0);
    checkOutput("wr_rdata",  {24'd0, rdata},   32'hA5);
    checkOutput("wr_err",    {31'd0, err},     32'h0);
    checkOutput("wr_busy_e", {31'd0, busy},    32'h0);
    tick();
    checkOutput("wr_done_pulse", {31'd0, done}, 32'h0);

    // CLEAR mask 0F from requester 1
    applyStimulus(2'b10, C_WRITE, 8'h00, C_CLEAR, 8'h0F);
    tick();
    checkOutput("clr_gnt", {30'd0, gnt},    32'h2);
    checkOutput("clr_pre", {24'd0, ff_pre}, 32'hF0);
    checkOutput("clr_clr", {24'd0, ff_clr}, 32'hFF);
    req = 2'b00;
    tick();
    tick();
    checkOutput("clr_done",  {31'd0, done},    32'h1);
    checkOutput("clr_id",    {31'd0, done_id}, 32'h1);
    checkOutput("clr_rdata", {24'd0, rdata},   32'hA0);
    checkOutput("clr_err",   {31'd0, err},     32'h0);
    tick();

    // PRESET mask 03 from requester 0
    applyStimulus(2'b01, C_PRESET, 8'h03, C_WRITE, 8'h00);
    tick();
    checkOutput("pre_gnt", {30'd0, gnt},    32'h1);
    checkOutput("pre_pre", {24'd0, ff_pre}, 32'hFF);
    checkOutput("pre_clr", {24'd0, ff_clr}, 32'hFC);
    req = 2'b00;
    tick();
    tick();
    checkOutput("pre_done",  {31'd0, done},  32'h1);
    checkOutput("pre_rdata", {24'd0, rdata}, 32'hA3);
    checkOutput("pre_err",   {31'd0, err},   32'h0);
    tick();

    // READ from requester 1: controls stay at hold throughout
    applyStimulus(2'b10, C_WRITE, 8'h00, C_READ, 8'h5A);
    tick();
    checkOutput("rd_gnt", {30'd0, gnt},    32'h2);
    checkOutput("rd_pre", {24'd0, ff_pre}, 32'hFF);
    checkOutput("rd_clr", {24'd0, ff_clr}, 32'hFF);
    req = 2'b00;
    tick();
    checkOutput("rd_pre_v", {24'd0, ff_pre}, 32'hFF);
    checkOutput("rd_clr_v", {24'd0, ff_clr}, 32'hFF);
    tick();
    checkOutput("rd_done",  {31'd0, done},    32'h1);
    checkOutput("rd_id",    {31'd0, done_id}, 32'h1);
    checkOutput("rd_rdata", {24'd0, rdata},   32'hA3);
    checkOutput("rd_err",   {31'd0, err},     32'h0);
    tick();

    // Zero-mask CLEAR from requester 1 is a no-op
    applyStimulus(2'b10, C_WRITE, 8'h00, C_CLEAR, 8'h00);
    tick();
    checkOutput("zm_pre", {24'd0, ff_pre}, 32'hFF);
    checkOutput("zm_clr", {24'd0, ff_clr}, 32'hFF);
    req = 2'b00;
    tick();
    tick();
    checkOutput("zm_done",  {31'd0, done},  32'h1);
    checkOutput("zm_rdata", {24'd0, rdata}, 32'hA3);
    checkOutput("zm_err",   {31'd0, err},   32'h0);
    tick();

    // Both requesting, held for four ops: grants alternate starting at 0
    alt_rdata[0] = 8'hB3;
    alt_rdata[1] = 8'hB2;
    alt_rdata[2] = 8'hB2;
    alt_rdata[3] = 8'hB2;
    applyStimulus(2'b11, C_PRESET, 8'h10, C_CLEAR, 8'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("alt%0d_gnt", k), {30'd0, gnt},
                  (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      checkOutput($sformatf("alt%0d_nogrant", k), {30'd0, gnt}, 32'h0);
      tick();
      checkOutput($sformatf("alt%0d_done", k),  {31'd0, done}, 32'h1);
      checkOutput($sformatf("alt%0d_id", k),    {31'd0, done_id},
                  (k % 2 == 0) ? 32'h0 : 32'h1);
      checkOutput($sformatf("alt%0d_rdata", k), {24'd0, rdata},
                  {24'd0, alt_rdata[k]});
    end
    req = 2'b00;
    tick();
    checkOutput("alt_end_gnt",  {30'd0, gnt},  32'h0);
    checkOutput("alt_end_done", {31'd0, done}, 32'h0);

    // Bit0 of the bank readback stuck low: WRITE FF must flag err
    stuck = 1'b1;
    applyStimulus(2'b01, C_WRITE, 8'hFF, C_WRITE, 8'h00);
    tick();
    req = 2'b00;
    tick();
    tick();
    checkOutput("stk_done",  {31'd0, done},  32'h1);
    checkOutput("stk_rdata", {24'd0, rdata}, 32'hFE);
    checkOutput("stk_err",   {31'd0, err},   32'h1);
    stuck = 1'b0;
    tick();

    // Reset landing on the edge that ends APPLY of WRITE 3C
    applyStimulus(2'b01, C_WRITE, 8'h3C, C_WRITE, 8'h00);
    tick();
    checkOutput("ra_gnt", {30'd0, gnt}, 32'h1);
    req   = 2'b00;
    clr_n = 1'b0;
    tick();
    checkIdleOutputs("ra_rst");
    checkOutput("ra_err",     {31'd0, err},     32'h0);
    checkOutput("ra_rdata",   {24'd0, rdata},   32'h0);
    checkOutput("ra_done_id", {31'd0, done_id}, 32'h0);
    clr_n = 1'b1;
    tick();
    checkOutput("ra_nodone1", {31'd0, done}, 32'h0);
    tick();
    checkOutput("ra_nodone2", {31'd0, done}, 32'h0);

    applyStimulus(2'b01, C_READ, 8'h00, C_WRITE, 8'h00);
    tick();
    checkOutput("ra_rd_gnt", {30'd0, gnt}, 32'h1);
    req = 2'b00;
    tick();
    tick();
    checkOutput("ra_rd_done",  {31'd0, done},  32'h1);
    checkOutput("ra_rd_rdata", {24'd0, rdata}, 32'h3C);
    checkOutput("ra_rd_err",   {31'd0, err},   32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
